// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions for the iterative cipher:
//   Nb           - number of 32-bit columns in the AES state (always 4)
//   aes_state_t  - 16-byte state, column-major: byte index = row + 4*column,
//                  byte 0 sits in the most significant bits so a 128-bit block
//                  maps onto the state with a plain assignment
//   aes_fsm_t    - cipher controller states
//   xtime        - multiply by x (0x02) in GF(2^8) modulo x^8+x^4+x^3+x+1
// No ports (package).
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int Nb = 4;

    typedef logic [0:4*Nb-1][7:0] aes_state_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } aes_fsm_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// -----------------------------------------------------------------------------
// aes_sbox
// Combinational AES forward S-box: multiplicative inverse in GF(2^8)
// followed by the affine transform with constant 0x63.
// Ports:
//   i_byte  in   8  input byte
//   o_byte  out  8  substituted byte
// -----------------------------------------------------------------------------
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    logic [7:0] w_x2, w_x3, w_x6, w_x12, w_x15, w_x30, w_x60, w_x120, w_x240, w_x252;
    logic [7:0] w_inv;

    // Inverse as x^254 via an addition chain; 0 maps to 0 naturally.
    assign w_x2   = gf_mul(i_byte, i_byte);
    assign w_x3   = gf_mul(w_x2, i_byte);
    assign w_x6   = gf_mul(w_x3, w_x3);
    assign w_x12  = gf_mul(w_x6, w_x6);
    assign w_x15  = gf_mul(w_x12, w_x3);
    assign w_x30  = gf_mul(w_x15, w_x15);
    assign w_x60  = gf_mul(w_x30, w_x30);
    assign w_x120 = gf_mul(w_x60, w_x60);
    assign w_x240 = gf_mul(w_x120, w_x120);
    assign w_x252 = gf_mul(w_x240, w_x12);
    assign w_inv  = gf_mul(w_x252, w_x2);

    // Affine transform: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63
    assign o_byte = w_inv
                  ^ {w_inv[6:0], w_inv[7]}
                  ^ {w_inv[5:0], w_inv[7:6]}
                  ^ {w_inv[4:0], w_inv[7:5]}
                  ^ {w_inv[3:0], w_inv[7:4]}
                  ^ 8'h63;

endmodule

// File: rtl/aes_cipher_iter.sv
// -----------------------------------------------------------------------------
// aes_cipher_iter
// Iterative AES encryption core, one round per clock. A block is accepted in
// IDLE (initial AddRoundKey applied on the accept edge), Nr rounds follow, and
// the ciphertext is held in DONE until the consumer takes it.
//
// Parameters:
//   Nk  key length in 32-bit words (4/6/8)
//   Nr  round count (10/12/14), must equal Nk + 6
//
// Ports:
//   clk        in   1    clock, rising edge
//   rst_n      in   1    asynchronous active-low reset
//   in_valid   in   1    plaintext offered
//   in_ready   out  1    high in IDLE
//   block      in   128  plaintext, byte 0 in [127:120]
//   w          in   32*(4*Nr+4)  expanded key, word k at w[32*k +: 32]
//   out_valid  out  1    high in DONE
//   out_ready  in   1    consumer takes ciphertext
//   out_block  out  128  ciphertext, byte 0 in [127:120]
//   busy       out  1    high in ROUND and DONE
//
// Build option:
//   AES_KEY_LATCH_EN  when defined, w is copied into a register on the accept
//                     edge and all rounds use the copy; otherwise w is read
//                     directly and must stay stable until out_valid.
// -----------------------------------------------------------------------------
module aes_cipher_iter
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [127:0]             block,
    input  logic [32*(4*Nr+4)-1:0]   w,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [127:0]             out_block,
    output logic                     busy
);

    localparam int         KW   = 32 * (4 * Nr + 4);
    localparam logic [3:0] LAST = 4'(Nr);

    if (Nr != Nk + 6) begin : g_bad_cfg
        $error("aes_cipher_iter: Nr must equal Nk + 6");
    end

    aes_fsm_t    r_fsm;
    aes_fsm_t    w_fsm_nxt;
    logic [3:0]  r_rnd;
    aes_state_t  r_state;
    aes_state_t  w_sb;
    aes_state_t  w_sr;
    aes_state_t  w_mc;
    aes_state_t  w_rk0;
    aes_state_t  w_rk_cur;
    aes_state_t  w_rnd_out;
    logic [KW-1:0] w_key;
    logic        w_accept;
    logic        w_last;

    // Round key i is words 4i..4i+3; word c becomes state column c.
    function automatic aes_state_t rk_at(input logic [KW-1:0] k, input logic [3:0] idx);
        aes_state_t s;
        for (int c = 0; c < Nb; c++) begin
            s[4*c +: 4] = k[128*int'(idx) + 32*c +: 32];
        end
        return s;
    endfunction

`ifdef AES_KEY_LATCH_EN
    // Data-only register: no reset needed, it is always written before use.
    logic [KW-1:0] r_key;

    always_ff @(posedge clk) begin
        if (w_accept) r_key <= w;
    end

    assign w_key = r_key;
`else
    assign w_key = w;
`endif

    assign w_accept = in_valid && (r_fsm == ST_IDLE);
    assign w_last   = (r_rnd == LAST);
    // Round 0 key always comes from the live input: it is consumed on the
    // accept edge itself, before any copy could exist.
    assign w_rk0    = rk_at(w, 4'd0);
    assign w_rk_cur = rk_at(w_key, r_rnd);

    // SubBytes, ShiftRows, MixColumns
    for (genvar g = 0; g < 4*Nb; g++) begin : g_sbox
        aes_sbox u_sbox (
            .i_byte (r_state[g]),
            .o_byte (w_sb[g])
        );
    end

    for (genvar c = 0; c < Nb; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign w_sr[r + 4*c] = w_sb[r + 4*((c + r) % Nb)];
            // 2*a[r] ^ 3*a[r+1] ^ a[r+2] ^ a[r+3]
            assign w_mc[r + 4*c] = xtime(w_sr[4*c + r])
                                 ^ xtime(w_sr[4*c + (r + 1) % 4]) ^ w_sr[4*c + (r + 1) % 4]
                                 ^ w_sr[4*c + (r + 2) % 4]
                                 ^ w_sr[4*c + (r + 3) % 4];
        end
    end

    // Final round skips MixColumns.
    assign w_rnd_out = w_last ? (w_sr ^ w_rk_cur) : (w_mc ^ w_rk_cur);

    // Controller
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm <= ST_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        unique case (r_fsm)
            ST_IDLE:  if (in_valid)  w_fsm_nxt = ST_ROUND;
            ST_ROUND: if (w_last)    w_fsm_nxt = ST_DONE;
            ST_DONE:  if (out_ready) w_fsm_nxt = ST_IDLE;
            default:                 w_fsm_nxt = ST_IDLE;
        endcase
    end

    // State register and round counter; r_rnd saturates at Nr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= '0;
            r_rnd   <= 4'd0;
        end else if (w_accept) begin
            r_state <= block ^ w_rk0;
            r_rnd   <= 4'd1;
        end else if (r_fsm == ST_ROUND) begin
            r_state <= w_rnd_out;
            if (!w_last) r_rnd <= r_rnd + 4'd1;
        end
    end

    assign in_ready  = (r_fsm == ST_IDLE);
    assign out_valid = (r_fsm == ST_DONE);
    assign busy      = (r_fsm != ST_IDLE);
    assign out_block = r_state;

endmodule
